// File: rtl/stream_ser_pkg.sv
// rtl/stream_ser_pkg.sv - shared types and helpers for the wide-to-narrow stream serializer
package stream_ser_pkg;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_e;

  // Beat counter never narrower than one bit, even when a word is a single beat.
  function automatic int ser_cnt_width(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - splits each popped DATA_WIDTH word into OUT_WIDTH beats
// Pops a valid/grant FIFO and replays each word as RATIO beats, last_o on the final slice.
module stream_serializer
  import stream_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  grant_i
);

  localparam int OW_SAFE = (OUT_WIDTH < 1) ? 1 : OUT_WIDTH;
  localparam int RATIO   = DATA_WIDTH / OW_SAFE;
  localparam int CNT_W   = ser_cnt_width(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  if ((OUT_WIDTH < 1) || ((DATA_WIDTH % OW_SAFE) != 0)) begin : g_param_err
    $error("stream_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH >= 1");
  end

  ser_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    grant_o = 1'b0;
    valid_o = (state_q == SER_SEND);
    last_o  = valid_o && (cnt_q == CNT_LAST);
    data_o  = (MSB_FIRST != 0) ? shreg_q[DATA_WIDTH-1 -: OUT_WIDTH]
                               : shreg_q[OUT_WIDTH-1:0];

    case (state_q)
      SER_IDLE: begin
        grant_o = 1'b1;
        if (valid_i) begin
          shreg_d = data_i;
          cnt_d   = '0;
          state_d = SER_SEND;
        end
      end
      SER_SEND: begin
        if (grant_i) begin
          if (!last_o) begin
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << OUT_WIDTH) : (shreg_q >> OUT_WIDTH);
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            // Final beat leaving: refill in the same cycle so back-to-back words have no bubble.
            grant_o = 1'b1;
            if (valid_i) begin
              shreg_d = data_i;
              cnt_d   = '0;
            end else begin
              state_d = SER_IDLE;
            end
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase

    // Abort wins over everything, including a pop that would otherwise happen now.
    if (clear_i) begin
      grant_o = 1'b0;
      state_d = SER_IDLE;
      cnt_d   = '0;
      shreg_d = shreg_q;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// tb/tb_stream_serializer.sv - randomized scoreboard bench for stream_serializer
module tb_stream_serializer;

  typedef logic [8:0] beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_i;
  logic        valid_i;
  logic        grant_i;
  logic [31:0] data_i;
  logic [2:0]  grant_o;
  logic [2:0]  valid_o;
  logic [2:0]  last_o;
  logic [7:0]  data_o [3];

  int checks = 0;
  int errors = 0;

  int ratio [3] = '{4, 4, 1};
  int msb   [3] = '{0, 1, 0};
  int rem   [3] = '{0, 0, 0};
  beat_t expq [3][$];

  logic        snap_clear;
  logic        snap_gi;
  logic [31:0] snap_data;
  logic        snap_acc [3];

  always #5 clk = ~clk;

  stream_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .clear_i(clear_i), .data_i(data_i), .valid_i(valid_i),
    .grant_o(grant_o[0]), .data_o(data_o[0]), .valid_o(valid_o[0]), .last_o(last_o[0]),
    .grant_i(grant_i)
  );

  stream_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .clear_i(clear_i), .data_i(data_i), .valid_i(valid_i),
    .grant_o(grant_o[1]), .data_o(data_o[1]), .valid_o(valid_o[1]), .last_o(last_o[1]),
    .grant_i(grant_i)
  );

  stream_serializer #(.DATA_WIDTH(8), .OUT_WIDTH(8), .MSB_FIRST(0)) u_r1 (
    .clk(clk), .rst(rst), .clear_i(clear_i), .data_i(data_i[7:0]), .valid_i(valid_i),
    .grant_o(grant_o[2]), .data_o(data_o[2]), .valid_o(valid_o[2]), .last_o(last_o[2]),
    .grant_i(grant_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every downstream handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int d = 0; d < 3; d++) begin
        if (valid_o[d] && grant_i) begin
          if (expq[d].size() == 0) begin
            check($sformatf("dut%0d_unexpected_beat", d), {23'd0, last_o[d], data_o[d]}, 32'h1ff);
          end else begin
            beat_t e;
            e = expq[d].pop_front();
            check($sformatf("dut%0d_beat_data", d), {24'd0, data_o[d]}, {24'd0, e[7:0]});
            check($sformatf("dut%0d_beat_last", d), {31'd0, last_o[d]}, {31'd0, e[8]});
          end
        end
      end
    end
  end

  // Reference model: tracks beats left in the word in flight; predicts pops and valid.
  always @(negedge clk) begin
    snap_clear = clear_i;
    snap_gi    = grant_i;
    snap_data  = data_i;
    for (int d = 0; d < 3; d++) begin
      logic exp_grant;
      exp_grant = !clear_i && ((rem[d] == 0) || ((rem[d] == 1) && grant_i));
      snap_acc[d] = (rst === 1'b0) && exp_grant && valid_i;
      if (rst === 1'b0) begin
        check($sformatf("dut%0d_grant_o", d), {31'd0, grant_o[d]}, {31'd0, exp_grant});
        check($sformatf("dut%0d_valid_o", d), {31'd0, valid_o[d]}, {31'd0, rem[d] != 0});
      end
    end
  end

  always @(posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      expq[d].delete();
      rem[d] = 0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst !== 1'b0) begin
        expq[d].delete();
        rem[d] = 0;
      end else if (snap_clear) begin
        expq[d].delete();
        rem[d] = 0;
      end else begin
        if (rem[d] > 0 && snap_gi) rem[d] = rem[d] - 1;
        if (snap_acc[d]) begin
          rem[d] = ratio[d];
          for (int k = 0; k < ratio[d]; k++) begin
            int idx;
            logic [7:0] b;
            idx = (msb[d] != 0) ? (ratio[d] - 1 - k) : k;
            b = 8'((snap_data >> (8 * idx)) & 32'hff);
            expq[d].push_back({k == ratio[d] - 1, b});
          end
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic g, input logic c, input logic [31:0] d);
    @(posedge clk);
    #1;
    valid_i = v;
    grant_i = g;
    clear_i = c;
    data_i  = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_valid%0d", tag, d), {31'd0, valid_o[d]}, 32'd0);
      check($sformatf("%s_last%0d", tag, d), {31'd0, last_o[d]}, 32'd0);
      check($sformatf("%s_grant%0d", tag, d), {31'd0, grant_o[d]}, 32'd1);
      check($sformatf("%s_data%0d", tag, d), {24'd0, data_o[d]}, 32'd0);
    end
  endtask

  initial begin
    int nvalid;
    rst = 1'b1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    grant_i = 1'b1;
    data_i  = '0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word, full throughput.
    cyc(1, 1, 0, 32'hDDCCBBAA);
    repeat (6) cyc(0, 1, 0, 32'h0);

    // Back-to-back words with valid held: eight beats, no idle cycle.
    cyc(1, 1, 0, 32'h04030201);
    nvalid = 0;
    repeat (4) begin
      cyc(1, 1, 0, 32'h08070605);
      @(negedge clk);
      if (valid_o[0]) nvalid++;
    end
    repeat (4) begin
      cyc(0, 1, 0, 32'h0);
      @(negedge clk);
      if (valid_o[0]) nvalid++;
    end
    check("back_to_back_beats", nvalid, 8);
    repeat (3) cyc(0, 1, 0, 32'h0);

    // Stall on the second beat: BB must hold with last_o low.
    cyc(1, 1, 0, 32'hDDCCBBAA);
    cyc(0, 1, 0, 32'h0);
    repeat (3) begin
      cyc(0, 0, 0, 32'h0);
      @(negedge clk);
      check("stall_data", {24'd0, data_o[0]}, 32'hBB);
      check("stall_last", {31'd0, last_o[0]}, 32'd0);
    end
    repeat (6) cyc(0, 1, 0, 32'h0);

    // Clear while the second beat is handshaked; next word restarts from its first slice.
    cyc(1, 1, 0, 32'hDDCCBBAA);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 1, 32'h0);
    cyc(1, 1, 0, 32'h44332211);
    @(negedge clk);
    check("post_clear_idle_grant", {31'd0, grant_o[0]}, 32'd1);
    cyc(0, 1, 0, 32'h0);
    @(negedge clk);
    check("post_clear_first_beat", {24'd0, data_o[0]}, 32'h11);
    repeat (5) cyc(0, 1, 0, 32'h0);

    // Async reset mid-word.
    cyc(1, 1, 0, 32'hDDCCBBAA);
    cyc(0, 1, 0, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) cyc(0, 1, 0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 30) == 0, $urandom);
    end

    repeat (10) cyc(0, 1, 0, 32'h0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d_drained", d), expq[d].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
